// File: rtl/oc_led_array.sv
// oc_led_array: multi-channel PWM LED driver with off/on/blink/heartbeat/breathe animation and a
// valid/ready register port. Define OC_LED_ARRAY_GAMMA_EN for a squared brightness curve (+1 cycle).
module oc_led_array #(
  parameter int ClockHz      = 100_000_000,
  parameter int LedCount     = 4,
  parameter int BrightBits   = 6,
  parameter int PrescaleBits = 12
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfgValid,
  output logic                cfgReady,
  input  logic                cfgWrite,
  input  logic [7:0]          cfgAddr,
  input  logic [31:0]         cfgWdata,
  output logic                rspValid,
  input  logic                rspReady,
  output logic [31:0]         rspData,
  output logic                rspError,
  output logic [LedCount-1:0] ledOut
);
  localparam int B      = BrightBits;
  localparam int PreDiv = ClockHz / (2 ** (B + 12));
  localparam logic [PrescaleBits-1:0] InitPrescale = PrescaleBits'((PreDiv > 0) ? PreDiv - 1 : 0);
  localparam logic [31:0] CtrlMask = 32'h80F7_FF07;
  localparam logic [31:0] IdWord   = {16'h4C44, 8'(B), 8'(LedCount)};
  localparam logic [8:0]  LastAddr = 9'(LedCount + 1);

  // Full-scale bright passes the ramp untouched so a 100% channel reaches solid on.
  function automatic logic [B-1:0] scale_ramp(input logic [B-1:0] ramp, input logic [B-1:0] bright);
    logic [2*B-1:0] prod;
    prod = {{B{1'b0}}, ramp} * {{B{1'b0}}, bright};
    return (&bright) ? ramp : B'(prod >> B);
  endfunction

  function automatic logic duty(input logic [B-1:0] pwm, input logic [B-1:0] lvl);
    return (&lvl) || (pwm < lvl);
  endfunction

`ifdef OC_LED_ARRAY_GAMMA_EN
  function automatic logic [B-1:0] gamma(input logic [B-1:0] x);
    logic [2*B-1:0] sq;
    sq = {{B{1'b0}}, x} * {{B{1'b0}}, x};
    return (&x) ? x : B'(sq >> B);
  endfunction
`endif

  logic [PrescaleBits-1:0] r_prescale;
  logic [PrescaleBits-1:0] r_pre_cnt;
  logic [B-1:0]            r_pwm;
  logic [7:0]              r_intra;
  logic [3:0]              r_step;
  logic [31:0]             r_ctrl [LedCount];
  logic                    r_rsp_valid;
  logic                    r_rsp_error;
  logic [31:0]             r_rsp_data;
  logic [LedCount-1:0]     r_led;

  logic                    w_accept;
  logic                    w_addr_ok;
  logic                    w_pre_wr;
  logic                    w_pulse;
  logic [31:0]             w_rdata;
  logic [B-1:0]            w_lvl [LedCount];
  logic [LedCount-1:0]     w_inv;

  assign cfgReady  = !r_rsp_valid || rspReady;
  assign w_accept  = cfgValid && cfgReady;
  assign w_addr_ok = {1'b0, cfgAddr} <= LastAddr;
  assign w_pre_wr  = w_accept && cfgWrite && (cfgAddr == 8'd1);
  assign w_pulse   = (r_pre_cnt == r_prescale);

  assign rspValid = r_rsp_valid;
  assign rspData  = r_rsp_data;
  assign rspError = r_rsp_error;
  assign ledOut   = r_led;

  always_comb begin
    w_rdata = '0;
    if (cfgAddr == 8'd0) w_rdata = IdWord;
    else if (cfgAddr == 8'd1) w_rdata = 32'(r_prescale);
    else
      for (int i = 0; i < LedCount; i++)
        if (cfgAddr == 8'(i + 2)) w_rdata = r_ctrl[i];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_prescale <= InitPrescale;
      for (int i = 0; i < LedCount; i++) r_ctrl[i] <= '0;
    end else if (w_accept && cfgWrite) begin
      if (cfgAddr == 8'd1) r_prescale <= cfgWdata[PrescaleBits-1:0];
      for (int i = 0; i < LedCount; i++)
        if (cfgAddr == 8'(i + 2)) r_ctrl[i] <= cfgWdata & CtrlMask;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_error <= !w_addr_ok;
      r_rsp_data  <= (cfgWrite || !w_addr_ok) ? '0 : w_rdata;
    end else if (rspReady) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Timebase chain: prescale -> pwm slot -> intra-step -> animation step.
  always_ff @(posedge clock) begin
    if (!reset || w_pre_wr) begin
      r_pre_cnt <= '0;
      r_pwm     <= '0;
      r_intra   <= '0;
      r_step    <= '0;
    end else if (w_pulse) begin
      r_pre_cnt <= '0;
      r_pwm     <= r_pwm + 1'b1;
      if (&r_pwm) begin
        r_intra <= r_intra + 1'b1;
        if (&r_intra) r_step <= r_step + 1'b1;
      end
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < LedCount; g++) begin : g_ch
    logic [3:0]   w_s;
    logic [B-1:0] w_r;
    logic [B-1:0] w_bright;
    logic [B-1:0] w_ramp;
    logic [B-1:0] w_level;

    always_comb begin
      w_s      = r_step + r_ctrl[g][23:20];
      w_r      = B'({w_s[2:0], r_intra} >> (11 - B));
      w_bright = r_ctrl[g][8 +: B];
      w_ramp   = '0;
      w_level  = '0;
      case (r_ctrl[g][2:0])
        3'd1: w_level = w_bright;
        3'd2: if (w_s[0] && (w_s[3:1] < r_ctrl[g][18:16])) w_level = w_bright;
        3'd3: begin
          if (w_s == 4'd0 || w_s == 4'd2) w_ramp = w_r;
          else if (w_s == 4'd1 || w_s == 4'd3) w_ramp = ~w_r;
          w_level = scale_ramp(w_ramp, w_bright);
        end
        3'd4: begin
          w_ramp  = w_s[3] ? ~w_r : w_r;
          w_level = scale_ramp(w_ramp, w_bright);
        end
        default: ;
      endcase
    end

    assign w_lvl[g] = w_level;
    assign w_inv[g] = r_ctrl[g][31];
  end

`ifdef OC_LED_ARRAY_GAMMA_EN
  logic [B-1:0]        r_lvl_p1 [LedCount];
  logic [B-1:0]        r_pwm_p1;
  logic [LedCount-1:0] r_inv_p1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pwm_p1 <= '0;
      r_inv_p1 <= '0;
      r_led    <= '0;
      for (int i = 0; i < LedCount; i++) r_lvl_p1[i] <= '0;
    end else begin
      // p1: gamma-mapped level; then duty compare into the output register
      r_pwm_p1 <= r_pwm;
      r_inv_p1 <= w_inv;
      for (int i = 0; i < LedCount; i++) begin
        r_lvl_p1[i] <= gamma(w_lvl[i]);
        r_led[i]    <= duty(r_pwm_p1, r_lvl_p1[i]) ^ r_inv_p1[i];
      end
    end
  end
`else
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < LedCount; i++)
        r_led[i] <= duty(r_pwm, w_lvl[i]) ^ w_inv[i];
    end
  end
`endif

endmodule

// File: tb/tb_oc_led_array.sv
// Randomized bench for oc_led_array (default parameters) against a cycle-count based reference model.
module tb_oc_led_array;
  logic        clk;
  logic        rst_n;
  logic        cfgValid;
  logic        cfgReady;
  logic        cfgWrite;
  logic [7:0]  cfgAddr;
  logic [31:0] cfgWdata;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspData;
  logic        rspError;
  logic [3:0]  ledOut;

  int total = 0;
  int bad   = 0;

  // Reference state: cycles since the counters were last cleared, plus the register file.
  int          m_n;
  int          m_pre;
  logic [31:0] m_ctrl [4];
  logic        m_rv;
  logic        m_re;
  logic [31:0] m_rd;
  logic [3:0]  e_led;
`ifdef OC_LED_ARRAY_GAMMA_EN
  logic [3:0]  e_led_p;
`endif

  int          cnt [4];
  logic [31:0] rdat;
  logic        rerr;

  oc_led_array dut (
    .clock    (clk),
    .reset    (rst_n),
    .cfgValid (cfgValid),
    .cfgReady (cfgReady),
    .cfgWrite (cfgWrite),
    .cfgAddr  (cfgAddr),
    .cfgWdata (cfgWdata),
    .rspValid (rspValid),
    .rspReady (rspReady),
    .rspData  (rspData),
    .rspError (rspError),
    .ledOut   (ledOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_led(input int n);
    logic [3:0] v;
    int pulses, pwm, intra, step, s, r, br, lvl, ramp;
    pulses = n / (m_pre + 1);
    pwm    = pulses % 64;
    intra  = (pulses / 64) % 256;
    step   = (pulses / 16384) % 16;
    for (int c = 0; c < 4; c++) begin
      s    = (step + int'(m_ctrl[c][23:20])) % 16;
      r    = ((s % 8) * 256 + intra) / 32;
      br   = int'(m_ctrl[c][13:8]);
      lvl  = 0;
      ramp = 0;
      case (m_ctrl[c][2:0])
        3'd1: lvl = br;
        3'd2: lvl = (s % 2 == 1 && s / 2 < int'(m_ctrl[c][18:16])) ? br : 0;
        3'd3: begin
          if (s == 0 || s == 2) ramp = r;
          else if (s == 1 || s == 3) ramp = 63 - r;
          lvl = (br == 63) ? ramp : ramp * br / 64;
        end
        3'd4: begin
          ramp = (s < 8) ? r : 63 - r;
          lvl  = (br == 63) ? ramp : ramp * br / 64;
        end
        default: lvl = 0;
      endcase
`ifdef OC_LED_ARRAY_GAMMA_EN
      if (lvl != 63) lvl = lvl * lvl / 64;
`endif
      v[c] = ((lvl == 63) || (pwm < lvl)) ^ m_ctrl[c][31];
    end
    return v;
  endfunction

  function automatic logic [31:0] reg_read(input logic [7:0] a);
    if (a == 8'd0) return 32'h4C44_0604;
    if (a == 8'd1) return 32'(m_pre);
    return m_ctrl[int'(a) - 2];
  endfunction

  // Reference model, advanced on every rising edge.
  initial begin
    logic clr;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_n = 0; m_pre = 380; m_rv = 1'b0; m_re = 1'b0; m_rd = '0; e_led = '0;
`ifdef OC_LED_ARRAY_GAMMA_EN
        e_led_p = '0;
`endif
        for (int c = 0; c < 4; c++) m_ctrl[c] = '0;
      end else begin
`ifdef OC_LED_ARRAY_GAMMA_EN
        e_led   = e_led_p;
        e_led_p = model_led(m_n);
`else
        e_led = model_led(m_n);
`endif
        clr = 1'b0;
        if (cfgValid && (!m_rv || rspReady)) begin
          m_rv = 1'b1;
          m_re = (cfgAddr > 8'd5);
          m_rd = (!cfgWrite && !m_re) ? reg_read(cfgAddr) : 32'h0;
          if (cfgWrite && cfgAddr == 8'd1) begin
            m_pre = int'(cfgWdata[11:0]);
            clr   = 1'b1;
          end else if (cfgWrite && cfgAddr >= 8'd2 && cfgAddr <= 8'd5) begin
            m_ctrl[int'(cfgAddr) - 2] = {cfgWdata[31], 7'b0, cfgWdata[23:20], 1'b0,
                                         cfgWdata[18:16], cfgWdata[15:8], 5'b0, cfgWdata[2:0]};
          end
        end else if (rspReady) begin
          m_rv = 1'b0;
        end
        m_n = clr ? 0 : m_n + 1;
      end
    end
  end

  // Continuous comparison of every output against the model.
  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      check("led", 32'(ledOut), 32'(e_led));
      check("rsp_valid", 32'(rspValid), 32'(m_rv));
      check("cfg_ready", 32'(cfgReady), 32'(!m_rv || rspReady));
      check("rsp_data", rspData, m_rd);
      check("rsp_error", 32'(rspError), 32'(m_re));
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic wr, input logic [7:0] a, input logic [31:0] d);
    int k;
    k = 0;
    cfgValid = 1'b1; cfgWrite = wr; cfgAddr = a; cfgWdata = d;
    @(negedge clk);
    while (!cfgReady && k < 50) begin
      k++;
      @(negedge clk);
    end
    check("cmd_wait", 32'(k < 50), 32'd1);
    sync();
    cfgValid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic e);
    cmd(1'b0, a, 32'h0);
    @(negedge clk);
    d = rspData;
    e = rspError;
    sync();
  endtask

  task automatic wait_n(input int target);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_n < target && k < 70000);
    check("wait_n", 32'(m_n >= target), 32'd1);
  endtask

  // Called at a falling edge; counts high samples per channel over 64 consecutive cycles.
  task automatic count64();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    repeat (64) begin
      for (int c = 0; c < 4; c++) cnt[c] += int'(ledOut[c]);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfgValid = 1'b0; cfgWrite = 1'b0; cfgAddr = '0; cfgWdata = '0; rspReady = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_led", 32'(ledOut), 32'h0);
    check("rst_rspvalid", 32'(rspValid), 32'h0);
    check("rst_rspdata", rspData, 32'h0);
    sync();
    rst_n = 1'b1;

    rd(8'd1, rdat, rerr);
    check("rst_prescale", rdat, 32'd380);
    rd(8'd0, rdat, rerr);
    check("id", rdat, 32'h4C44_0604);

    cmd(1'b1, 8'd1, 32'h0);
`ifdef OC_LED_ARRAY_GAMMA_EN
    cmd(1'b1, 8'd2, 32'h0000_2001);
`else
    cmd(1'b1, 8'd2, 32'h0000_1001);
`endif
    cmd(1'b1, 8'd3, 32'h0003_3F02);
    cmd(1'b1, 8'd4, 32'h0080_3F04);
    cmd(1'b1, 8'd5, 32'h0000_3F04);
    wait_n(100);
    count64();
    check("on_duty16", 32'(cnt[0]), 32'd16);
    sync();
`ifndef OC_LED_ARRAY_GAMMA_EN
    wait_n(4097);
    count64();
    check("breathe_ph0", 32'(cnt[3]), 32'd2);
    check("breathe_ph8", 32'(cnt[2]), 32'd61);
    sync();
`endif
    wait_n(20000);
    count64();
    check("blink_s1", 32'(cnt[1]), 32'd64);
    sync();
    wait_n(36000);
    count64();
    check("blink_s2", 32'(cnt[1]), 32'd0);
    sync();
    wait_n(50000);
    count64();
    check("blink_s3", 32'(cnt[1]), 32'd64);
    sync();

    rspReady = 1'b0;
    rd(8'd9, rdat, rerr);
    check("oor_err", 32'(rerr), 32'd1);
    check("oor_data", rdat, 32'h0);
    fork
      cmd(1'b1, 8'd4, 32'h0000_3F01);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_ready", 32'(cfgReady), 32'd0);
        end
        sync();
        rspReady = 1'b1;
      end
    join
    rd(8'd4, rdat, rerr);
    check("stall_write_kept", rdat, 32'h0000_3F01);

    cmd(1'b1, 8'd3, 32'hFFFF_FFFF);
    rd(8'd3, rdat, rerr);
    check("ctrl_mask", rdat, 32'h80F7_FF07);
    cmd(1'b1, 8'd0, 32'h1234_5678);
    rd(8'd0, rdat, rerr);
    check("id_ro", rdat, 32'h4C44_0604);
    check("id_noerr", 32'(rerr), 32'd0);

    cmd(1'b1, 8'd5, 32'h8000_0001);
    cmd(1'b1, 8'd4, 32'h0000_3F05);
    repeat (3) @(negedge clk);
    count64();
    check("invert_dark", 32'(cnt[3]), 32'd64);
    check("mode5_off", 32'(cnt[2]), 32'd0);
    sync();
    cmd(1'b1, 8'd5, 32'h8000_3F01);
    repeat (3) @(negedge clk);
    count64();
    check("invert_full", 32'(cnt[3]), 32'd0);
    sync();

    cmd(1'b1, 8'd1, 32'd7);
    repeat (37) sync();
    cmd(1'b1, 8'd1, 32'd2);
    repeat (20) sync();

    for (int it = 0; it < 300; it++) begin
      int op;
      logic [7:0] a;
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        cmd(1'b1, 8'($urandom_range(2, 5)), $urandom);
      end else if (op == 4) begin
        cmd(1'b1, 8'd1, 32'($urandom_range(0, 3)));
      end else if (op <= 6) begin
        a = 8'($urandom_range(0, 10));
        rd(a, rdat, rerr);
        check("rnd_err", 32'(rerr), 32'(a > 8'd5));
      end else if (op == 7) begin
        rspReady = 1'b0;
        repeat ($urandom_range(1, 3)) sync();
        rspReady = 1'b1;
      end else if (op == 8) begin
        cmd(1'b1, 8'($urandom_range(6, 255)), $urandom);
      end else begin
        repeat ($urandom_range(1, 80)) sync();
      end
    end

    rst_n = 1'b0;
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_led", 32'(ledOut), 32'h0);
    sync();
    rd(8'd1, rdat, rerr);
    check("midreset_prescale", rdat, 32'd380);
    repeat (4) sync();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
